// File: rtl/mips_pkg.sv
// Shared MIPS constants: instruction encodings, field positions and
// the fetch-stage state encoding.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;   // SLL r0,r0,0

   localparam logic [5:0] FUNC_ADD = 6'b100000;
   localparam logic [5:0] FUNC_SUB = 6'b100010;
   localparam logic [5:0] FUNC_AND = 6'b100100;
   localparam logic [5:0] FUNC_OR  = 6'b100101;
   localparam logic [5:0] FUNC_NOR = 6'b100111;
   localparam logic [5:0] FUNC_SLL = 6'b000000;
   localparam logic [5:0] FUNC_SRL = 6'b000010;
   localparam logic [5:0] FUNC_SRA = 6'b000011;
   localparam logic [5:0] FUNC_SLT = 6'b101010;
   localparam logic [5:0] FUNC_JR  = 6'b001000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int SH_HI  = 10;
   localparam int SH_LO  = 6;
   localparam int FN_HI  = 5;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   localparam logic [0:0] FETCH_ST = 1'b0;
   localparam logic [0:0] KILL_ST  = 1'b1;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] func;
   } rtype_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that arrived while
// decode was stalled.
module fetch_skid_buf
   import mips_pkg::*;
#(
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                drain,
   input  logic                clear,
   input  logic [31:0]         load_word,
   input  logic [PC_WIDTH-1:0] load_pc4,
   output logic                full,
   output logic [31:0]         word,
   output logic [PC_WIDTH-1:0] pc4
);

   logic                full_reg;
   logic [31:0]         word_reg;
   logic [PC_WIDTH-1:0] pc4_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         full_reg <= 1'b0;
         word_reg <= NOP_INSTR;
         pc4_reg  <= '0;
      end else if (load) begin
         full_reg <= 1'b1;
         word_reg <= load_word;
         pc4_reg  <= load_pc4;
      end else if (drain) begin
         full_reg <= 1'b0;
      end
   end

   assign full = full_reg;
   assign word = word_reg;
   assign pc4  = pc4_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: owns the PC, handshakes with
// instruction memory, absorbs stalls via a skid entry, squashes on redirect.
module fetch_stage #(
   parameter int                  PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter logic [31:0]         NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ready,
   input  logic [31:0]         imem_rdata,
   output logic                id_valid,
   output logic [31:0]         instr,
   output logic [5:0]          op,
   output logic [5:0]          func,
   output logic [4:0]          rs,
   output logic [4:0]          rt,
   output logic [4:0]          rd,
   output logic [4:0]          shamt,
   output logic [15:0]         imm,
   output logic [PC_WIDTH-1:0] pc_plus4
);
   import mips_pkg::*;

   logic [PC_WIDTH-1:0] pc_reg;
   logic [PC_WIDTH-1:0] target_reg;
   logic [PC_WIDTH-1:0] pc_plus4_reg;
   logic [31:0]         instr_reg;
   logic                id_valid_reg;
   logic [0:0]          state_reg;

   logic [PC_WIDTH-1:0] pc_next4;
   logic [PC_WIDTH-1:0] redirect_aligned;
   logic                fire;
   logic                skid_full;
   logic                skid_load;
   logic                skid_drain;
   logic [31:0]         skid_word;
   logic [PC_WIDTH-1:0] skid_pc4;
   logic                unused_bits;
   rtype_t              fields;

   assign unused_bits      = &{1'b0, redirect_pc[1:0]};
   assign redirect_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
   assign pc_next4         = pc_reg + PC_WIDTH'(4);

   // In KILL the old request is still outstanding and must be held until accepted.
   assign imem_req  = !reset && ((state_reg == KILL_ST) || !skid_full);
   assign imem_addr = pc_reg;
   assign fire      = imem_req && imem_ready;

   assign skid_load  = !redirect && (state_reg == FETCH_ST) && fire && stall;
   assign skid_drain = !redirect && (state_reg == FETCH_ST) && skid_full && !stall;

   fetch_skid_buf #(
      .PC_WIDTH (PC_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .drain     (skid_drain),
      .clear     (redirect),
      .load_word (imem_rdata),
      .load_pc4  (pc_next4),
      .full      (skid_full),
      .word      (skid_word),
      .pc4       (skid_pc4)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg       <= RESET_PC;
         target_reg   <= '0;
         pc_plus4_reg <= '0;
         instr_reg    <= NOP_INSTR;
         id_valid_reg <= 1'b0;
         state_reg    <= FETCH_ST;
      end else if (redirect) begin
         instr_reg    <= NOP_INSTR;
         id_valid_reg <= 1'b0;
         if (imem_req && !imem_ready) begin
            state_reg  <= KILL_ST;
            target_reg <= redirect_aligned;
         end else begin
            state_reg <= FETCH_ST;
            pc_reg    <= redirect_aligned;
         end
      end else if (state_reg == KILL_ST) begin
         // The word returned here belongs to the squashed path.
         if (imem_ready) begin
            pc_reg    <= target_reg;
            state_reg <= FETCH_ST;
         end
      end else if (skid_full) begin
         if (!stall) begin
            instr_reg    <= skid_word;
            pc_plus4_reg <= skid_pc4;
            id_valid_reg <= 1'b1;
         end
      end else if (fire) begin
         pc_reg <= pc_next4;
         if (!stall) begin
            instr_reg    <= imem_rdata;
            pc_plus4_reg <= pc_next4;
            id_valid_reg <= 1'b1;
         end
      end
   end

   assign fields   = rtype_t'(instr_reg);
   assign instr    = instr_reg;
   assign id_valid = id_valid_reg;
   assign pc_plus4 = pc_plus4_reg;
   assign op       = fields.op;
   assign rs       = fields.rs;
   assign rt       = fields.rt;
   assign rd       = fields.rd;
   assign shamt    = fields.shamt;
   assign func     = fields.func;
   assign imm      = instr_reg[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, a redirect-during-KILL
// sequence, then randomized traffic against a queue-based reference model.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  func;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [31:0] pc_plus4;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .instr       (instr),
      .op          (op),
      .func        (func),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .imm         (imm),
      .pc_plus4    (pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the IF/ID contents, a list of parked words, and the
   // redirect target owed once a squashed request finally returns.
   typedef struct packed {
      logic [31:0] w;
      logic [31:0] p;
   } entry_t;

   logic [31:0] m_pc, m_instr, m_pc4, m_target;
   bit          m_valid, m_kill, cur_rst;
   entry_t      parked[$];

   function automatic bit m_req(bit rst);
      return !rst && (m_kill || parked.size() == 0);
   endfunction

   task automatic model_step(input bit r, st, rdr, input logic [31:0] rpc,
                             input bit rdy, input logic [31:0] data);
      bit          req;
      logic [31:0] tgt;
      entry_t      e;
      req = m_req(r);
      tgt = rpc & 32'hFFFF_FFFC;
      if (r) begin
         m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_kill = 0; m_target = 0;
         parked.delete();
      end else if (rdr) begin
         m_instr = 0; m_valid = 0;
         parked.delete();
         if (req && !rdy) begin
            m_kill = 1; m_target = tgt;
         end else begin
            m_kill = 0; m_pc = tgt;
         end
      end else if (m_kill) begin
         if (rdy) begin
            m_kill = 0; m_pc = m_target;
         end
      end else if (parked.size() != 0) begin
         if (!st) begin
            e = parked.pop_front();
            m_instr = e.w; m_pc4 = e.p; m_valid = 1;
         end
      end else if (req && rdy) begin
         if (st) begin
            e.w = data; e.p = m_pc + 4;
            parked.push_back(e);
         end else begin
            m_instr = data; m_pc4 = m_pc + 4; m_valid = 1;
         end
         m_pc = m_pc + 4;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cycle(input bit r, st, rdr, input logic [31:0] rpc,
                        input bit rdy, input logic [31:0] data);
      reset = r; stall = st; redirect = rdr; redirect_pc = rpc;
      imem_ready = rdy; imem_rdata = data;
      model_step(r, st, rdr, rpc, rdy, data);
      cur_rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input int idx);
      logic [31:0] mi;
      mi = m_instr;
      check($sformatf("rnd%0d id_valid", idx), 32'(id_valid), 32'(m_valid));
      check($sformatf("rnd%0d instr", idx), instr, mi);
      check($sformatf("rnd%0d pc_plus4", idx), pc_plus4, m_pc4);
      check($sformatf("rnd%0d imem_req", idx), 32'(imem_req), 32'(m_req(cur_rst)));
      check($sformatf("rnd%0d imem_addr", idx), imem_addr, m_pc);
      check($sformatf("rnd%0d fields", idx), {op, rs, rt, rd, shamt, func, imm},
            {mi[31:26], mi[25:21], mi[20:16], mi[15:11], mi[10:6], mi[5:0], mi[15:0]});
   endtask

   typedef struct packed {
      bit          rst, stl, rdr;
      logic [31:0] rpc;
      bit          rdy;
      logic [31:0] data;
      bit          e_valid;
      logic [31:0] e_instr;
      bit          chk_pc4;
      logic [31:0] e_pc4;
      bit          e_req;
      logic [31:0] e_addr;
   } vec_t;

   function automatic vec_t mk(bit rst, stl, rdr, logic [31:0] rpc, bit rdy,
                               logic [31:0] data, bit ev, logic [31:0] ei,
                               bit cp, logic [31:0] ep, bit er, logic [31:0] ea);
      vec_t v;
      v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.data = data;
      v.e_valid = ev; v.e_instr = ei; v.chk_pc4 = cp; v.e_pc4 = ep;
      v.e_req = er; v.e_addr = ea;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      reset = 1; stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 0; imem_rdata = 0;
      cur_rst = 1;

      //          rst stl rdr rpc          rdy data          valid instr       cp pc4          req addr
      vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 32'h0,        1, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h00221820, 1, 32'h00221820, 1, 32'h4,        1, 32'h4));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h00221822, 1, 32'h00221822, 1, 32'h8,        1, 32'h8));
      vecs.push_back(mk(0, 0, 0, 0,            0, 32'hAAAA5555, 1, 32'h00221822, 1, 32'h8,        1, 32'h8));
      vecs.push_back(mk(0, 0, 0, 0,            0, 32'hAAAA5555, 1, 32'h00221822, 1, 32'h8,        1, 32'h8));
      vecs.push_back(mk(0, 0, 0, 0,            0, 32'hAAAA5555, 1, 32'h00221822, 1, 32'h8,        1, 32'h8));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h00851020, 1, 32'h00851020, 1, 32'hC,        1, 32'hC));
      vecs.push_back(mk(0, 1, 0, 0,            1, 32'h00A63022, 1, 32'h00851020, 1, 32'hC,        0, 32'h10));
      vecs.push_back(mk(0, 1, 0, 0,            1, 32'hDEADBEEF, 1, 32'h00851020, 1, 32'hC,        0, 32'h10));
      vecs.push_back(mk(0, 0, 0, 0,            0, 32'h0,        1, 32'h00A63022, 1, 32'h10,       1, 32'h10));
      vecs.push_back(mk(0, 0, 1, 32'h40,       1, 32'h11111111, 0, 32'h0,        0, 32'h0,        1, 32'h40));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h01095024, 1, 32'h01095024, 1, 32'h44,       1, 32'h44));
      vecs.push_back(mk(0, 0, 1, 32'h103,      0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h44));
      vecs.push_back(mk(0, 0, 0, 0,            0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h44));
      vecs.push_back(mk(0, 0, 0, 0,            0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h44));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h22222222, 0, 32'h0,        0, 32'h0,        1, 32'h100));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h014B6025, 1, 32'h014B6025, 1, 32'h104,      1, 32'h104));
      vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 1, 32'h33333333, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h016C6827, 1, 32'h016C6827, 1, 32'h0,        1, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0,            1, 32'h01AE7822, 1, 32'h016C6827, 1, 32'h0,        0, 32'h4));
      vecs.push_back(mk(1, 1, 0, 0,            1, 32'h44444444, 0, 32'h0,        1, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 32'h0));

      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy, vecs[i].data);
         check($sformatf("vec%0d id_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
         if (vecs[i].chk_pc4)
            check($sformatf("vec%0d pc_plus4", i), pc_plus4, vecs[i].e_pc4);
         check($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
         check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
         if (i == 1) begin
            check("vec1 op", 32'(op), 32'h0);
            check("vec1 func", 32'(func), 32'b100000);
            check("vec1 rs/rt/rd/shamt", {12'h0, rs, rt, rd, shamt}, {12'h0, 5'd1, 5'd2, 5'd3, 5'd0});
            check("vec1 imm", 32'(imm), 32'h1820);
         end
         if (i == 2) check("vec2 func", 32'(func), 32'b100010);
      end

      // Second redirect while a squashed request is outstanding replaces the target.
      cycle(0, 0, 1, 32'h200, 0, 32'h0);
      check("kill1 imem_addr", imem_addr, 32'h0);
      check("kill1 imem_req", 32'(imem_req), 32'h1);
      cycle(0, 0, 1, 32'h305, 0, 32'h0);
      check("kill2 imem_addr", imem_addr, 32'h0);
      cycle(0, 0, 0, 32'h0, 1, 32'hBAD0BAD0);
      check("kill3 imem_addr", imem_addr, 32'h304);
      check("kill3 id_valid", 32'(id_valid), 32'h0);
      check("kill3 instr", instr, 32'h0);
      cycle(0, 0, 0, 32'h0, 1, 32'h00221820);
      check("kill4 instr", instr, 32'h00221820);
      check("kill4 pc_plus4", pc_plus4, 32'h308);
      cycle(0, 1, 0, 32'h0, 0, 32'h0);
      check("stallhold instr", instr, 32'h00221820);
      check("stallhold id_valid", 32'(id_valid), 32'h1);
      check("stallhold imem_addr", imem_addr, 32'h308);

      cycle(1, 0, 0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1) == 1, $urandom);
         check_model(i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
